// File: rtl/load_store_unit_if.sv
// Request/response bundle between the execute stage and the load/store unit, and the
// data-memory port bundle driven by the load/store unit.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

interface lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage request into a word-aligned, byte-enabled
// req/ack memory access and returns extended load data with a one-cycle completion pulse.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic      CLK,
  input  logic      Reset,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    off_q, off_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] be_q, be_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          bad;
  logic [BW-1:0] be_dec;
  logic [DW-1:0] wdata_rep;
  logic [15:0]   lane;
  logic [DW-1:0] ld_ext;

  // Decode the incoming request: byte enables, lane-replicated store data, alignment.
  always_comb begin
    be_dec    = '0;
    wdata_rep = req.req_wdata;
    bad       = 1'b0;
    case (req.req_size)
      2'b00: begin
        be_dec    = 4'b0001 << req.req_addr[1:0];
        wdata_rep = {4{req.req_wdata[7:0]}};
      end
      2'b01: begin
        be_dec    = 4'b0011 << req.req_addr[1:0];
        wdata_rep = {2{req.req_wdata[15:0]}};
        bad       = req.req_addr[0];
      end
      2'b10: begin
        be_dec = 4'b1111;
        bad    = |req.req_addr[1:0];
      end
      default: bad = 1'b1;
    endcase
  end

  // Half loads are always 2-byte aligned here, so one byte-offset shift serves both sizes.
  always_comb begin
    lane = 16'(mem.mem_rdata >> {off_q, 3'b000});
    case (size_q)
      2'b00:   ld_ext = {{24{lane[7] & ~uns_q}}, lane[7:0]};
      2'b01:   ld_ext = {{16{lane[15] & ~uns_q}}, lane[15:0]};
      default: ld_ext = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          we_d    = req.req_we;
          size_d  = req.req_size;
          uns_d   = req.req_unsigned;
          off_d   = req.req_addr[1:0];
          addr_d  = {req.req_addr[AW-1:2], 2'b00};
          be_d    = be_dec;
          wdata_d = wdata_rep;
          if (bad) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem.mem_ack) begin
          rdata_d = we_q ? '0 : ld_ext;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        // Clear the response so the bus idles at zero between completions.
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req.req_ready  = (state_q == IDLE);
  assign req.busy       = (state_q != IDLE);
  assign req.resp_valid = (state_q == RESP);
  assign req.resp_rdata = rdata_q;
  assign req.resp_err   = err_q;
  assign mem.mem_req    = (state_q == ACCESS);
  assign mem.mem_we     = we_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_be     = be_q;
  assign mem.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses are queued at request time and
// compared when resp_valid appears; handshake timing is checked inline.
module tb_load_store_unit;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic  clk;
  logic  rst_n;
  int    errors = 0;
  int    checks = 0;
  resp_t exp_q[$];

  lsu_req_if rq ();
  lsu_mem_if mm ();

  load_store_unit #(.TIMEOUT(4)) dut (
    .CLK   (clk),
    .Reset (rst_n),
    .req   (rq),
    .mem   (mm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response scoreboard: every completion pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rq.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", rq.resp_rdata, e.rdata);
        check("resp_err", 32'(rq.resp_err), 32'(e.err));
      end
    end
  end

  // exp_n: ACCESS cycles expected (0 = rejected without memory access); ack_cyc: ACCESS
  // cycle in which memory acks (0 = never).
  task automatic run_req(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_cyc, input logic [31:0] rdata, input int exp_n,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
    int n;
    resp_t e;
    @(negedge clk);
    check({name, "_ready_idle"}, 32'(rq.req_ready), 32'd1);
    rq.req_valid    = 1'b1;
    rq.req_we       = we;
    rq.req_size     = size;
    rq.req_unsigned = uns;
    rq.req_addr     = addr;
    rq.req_wdata    = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    rq.req_valid = 1'b0;
    n = 0;
    while (mm.mem_req === 1'b1 && n < 20) begin
      n++;
      if (n == 1) begin
        check({name, "_mem_addr"}, mm.mem_addr, exp_addr);
        check({name, "_mem_be"}, 32'(mm.mem_be), 32'(exp_be));
        check({name, "_mem_we"}, 32'(mm.mem_we), 32'(we));
        if (we) check({name, "_mem_wdata"}, mm.mem_wdata, exp_wdata);
      end
      if (n == ack_cyc) begin
        mm.mem_ack   = 1'b1;
        mm.mem_rdata = rdata;
      end
      @(negedge clk);
      mm.mem_ack = 1'b0;
    end
    check({name, "_access_cycles"}, 32'(n), 32'(exp_n));
    check({name, "_resp_valid"}, 32'(rq.resp_valid), 32'd1);
    check({name, "_busy_resp"}, {30'd0, rq.busy, rq.req_ready}, 32'b10);
    @(negedge clk);
    check({name, "_after_resp"}, {29'd0, rq.req_ready, rq.resp_valid, mm.mem_req}, 32'b100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    rq.req_valid    = 1'b0;
    rq.req_we       = 1'b0;
    rq.req_size     = 2'b10;
    rq.req_unsigned = 1'b0;
    rq.req_addr     = '0;
    rq.req_wdata    = '0;
    mm.mem_ack      = 1'b0;
    mm.mem_rdata    = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {27'd0, rq.req_ready, rq.busy, rq.resp_valid, rq.resp_err, mm.mem_req},
          32'b10000);
    check("rst_rdata", rq.resp_rdata, 32'd0);
    check("rst_mem", {mm.mem_we, mm.mem_be} | mm.mem_addr | mm.mem_wdata, 32'd0);
    rst_n = 1'b1;

    //       name    we    size   uns   addr   wdata        ack rdata        n  mem_addr be       wdata        resp_rdata   err
    run_req("lw",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,       3, 32'hDEADBEEF, 3, 32'h10, 4'b1111, 32'h0,       32'hDEADBEEF, 1'b0);
    run_req("lb",   1'b0, 2'b00, 1'b0, 32'h13, 32'h0,       1, 32'h80FF1234, 1, 32'h10, 4'b1000, 32'h0,       32'hFFFFFF80, 1'b0);
    run_req("lbu",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0,       1, 32'h80FF1234, 1, 32'h10, 4'b1000, 32'h0,       32'h00000080, 1'b0);
    run_req("lh",   1'b0, 2'b01, 1'b0, 32'h12, 32'h0,       2, 32'h80FF1234, 2, 32'h10, 4'b1100, 32'h0,       32'hFFFF80FF, 1'b0);
    run_req("lhu",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0,       1, 32'h80FF1234, 1, 32'h10, 4'b1100, 32'h0,       32'h000080FF, 1'b0);
    run_req("lb0",  1'b0, 2'b00, 1'b0, 32'h20, 32'h0,       1, 32'h0000007F, 1, 32'h20, 4'b0001, 32'h0,       32'h0000007F, 1'b0);
    run_req("sh",   1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 2, 32'hFFFFFFFF, 2, 32'h20, 4'b1100, 32'hABCDABCD, 32'h0,       1'b0);
    run_req("sb",   1'b1, 2'b00, 1'b0, 32'h21, 32'h12345678, 1, 32'hFFFFFFFF, 1, 32'h20, 4'b0010, 32'h78787878, 32'h0,       1'b0);
    run_req("sw",   1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D, 1, 32'h0,       1, 32'h24, 4'b1111, 32'hCAFEF00D, 32'h0,       1'b0);
    run_req("lwmis",1'b0, 2'b10, 1'b0, 32'h06, 32'h0,       1, 32'h0,        0, 32'h0,  4'b0000, 32'h0,       32'h0,        1'b1);
    run_req("lhmis",1'b0, 2'b01, 1'b0, 32'h11, 32'h0,       1, 32'h0,        0, 32'h0,  4'b0000, 32'h0,       32'h0,        1'b1);
    run_req("rsvd", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0,       1, 32'h0,        0, 32'h0,  4'b0000, 32'h0,       32'h0,        1'b1);
    run_req("tmo",  1'b0, 2'b10, 1'b0, 32'h30, 32'h0,       0, 32'h0,        4, 32'h30, 4'b1111, 32'h0,       32'h0,        1'b1);
    run_req("lastack",1'b0,2'b10,1'b0, 32'h34, 32'h0,       4, 32'h12345678, 4, 32'h34, 4'b1111, 32'h0,       32'h12345678, 1'b0);

    // Reset in the second ACCESS cycle; no response may ever appear for this request.
    @(negedge clk);
    rq.req_valid = 1'b1;
    rq.req_we    = 1'b0;
    rq.req_size  = 2'b10;
    rq.req_addr  = 32'h40;
    @(negedge clk);
    rq.req_valid = 1'b0;
    check("rstmid_access1", 32'(mm.mem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_ctrl", {27'd0, rq.req_ready, rq.busy, rq.resp_valid, rq.resp_err, mm.mem_req},
          32'b10000);
    check("rstmid_rdata", rq.resp_rdata, 32'd0);
    check("rstmid_mem", {mm.mem_we, mm.mem_be} | mm.mem_addr | mm.mem_wdata, 32'd0);
    rst_n        = 1'b1;
    mm.mem_ack   = 1'b1;
    mm.mem_rdata = 32'hBADBAD00;
    @(negedge clk);
    mm.mem_ack = 1'b0;
    check("late_ack_no_resp", {30'd0, rq.resp_valid, mm.mem_req}, 32'd0);
    @(negedge clk);
    check("late_ack_idle", {30'd0, rq.req_ready, rq.resp_valid}, 32'b10);
    run_req("lw_post", 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1, 32'h0BADF00D, 1, 32'h44, 4'b1111,
            32'h0, 32'h0BADF00D, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
